// File: rtl/mips_instr_encoder.sv
// Encodes symbolic instruction commands into 32-bit MIPS words and writes them
// sequentially into instruction memory through a registered write port.
// Latency: 1 cycle from accept to write. Backpressure: cmd_ready low unless LOADing and not full.
//
// Ports:
//   clk, reset (sync, active-low)     : clock and reset
//   prog_start / prog_end             : pulses that open / close a program load
//   cmd_valid / cmd_ready / cmd_*     : command handshake and instruction fields
//   im_we / im_addr / im_wdata        : instruction-memory write port (registered)
//   count / full / done               : words accepted, capacity reached, load finished
module mips_instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_start,
    input  logic              prog_end,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_kind,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [5:0]        cmd_funct,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0] LAST_C  = DEPTH_C - (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [31:0]         im_wdata_q, im_wdata_d;
    logic                accept;

    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [4:0]  rd,
        input logic [5:0]  funct,
        input logic [15:0] imm,
        input logic [25:0] target
    );
        logic [31:0] w;
        case (kind)
            3'd1:    w = {6'b100011, rs, rt, imm};            // LW
            3'd2:    w = {6'b101011, rs, rt, imm};            // SW
            3'd3:    w = {6'b000100, rs, rt, imm};            // BEQ
            3'd4:    w = {6'b001000, rs, rt, imm};            // ADDI
            3'd5:    w = {6'b000010, target};                 // J
            3'd6:    w = {6'b001101, rs, rt, imm};            // ORI
            3'd7:    w = {6'b000101, rs, rt, imm};            // BNE
            default: w = {6'b000000, rs, rt, rd, 5'b00000, funct}; // R
        endcase
        return w;
    endfunction

    // full is derived from count: count saturates at DEPTH, so the MSB alone
    // would do, but the explicit compare keeps intent obvious.
    assign full      = (count_q == DEPTH_C);
    assign done      = (state_q == S_DONE);
    assign cmd_ready = (state_q == S_LOAD) && !full;
    assign accept    = cmd_valid && cmd_ready;

    assign count     = count_q;
    assign im_we     = im_we_q;
    assign im_addr   = im_addr_q;
    assign im_wdata  = im_wdata_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;

        if (accept) begin
            im_we_d    = 1'b1;
            // A simultaneous prog_start restarts the program, so this word lands at 0.
            im_addr_d  = prog_start ? '0 : count_q[ADDR_W-1:0];
            im_wdata_d = encode(cmd_kind, cmd_rs, cmd_rt, cmd_rd,
                                cmd_funct, cmd_imm, cmd_target);
        end

        if (prog_start) begin
            // prog_start overrides prog_end and any fill-triggered DONE.
            state_d = S_LOAD;
            count_d = accept ? ONE_C : '0;
        end else begin
            if (accept) begin
                count_d = count_q + ONE_C;
            end
            case (state_q)
                S_LOAD: begin
                    if (prog_end || (accept && (count_q == LAST_C))) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder with a small (4-word) memory so the
// capacity boundary is reachable. Expected writes are queued when a command is
// driven and checked by a monitor whenever the DUT raises im_we.
module tb_mips_instr_encoder;

    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              prog_start;
    logic              prog_end;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_kind;
    logic [4:0]        cmd_rs;
    logic [4:0]        cmd_rt;
    logic [4:0]        cmd_rd;
    logic [5:0]        cmd_funct;
    logic [15:0]       cmd_imm;
    logic [25:0]       cmd_target;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard entry: {address, word}
    logic [ADDR_W+31:0] sb_q[$];

    mips_instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .prog_start (prog_start),
        .prog_end   (prog_end),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_kind   (cmd_kind),
        .cmd_rs     (cmd_rs),
        .cmd_rt     (cmd_rt),
        .cmd_rd     (cmd_rd),
        .cmd_funct  (cmd_funct),
        .cmd_imm    (cmd_imm),
        .cmd_target (cmd_target),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .count      (count),
        .full       (full),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int addr, input logic [31:0] word);
        sb_q.push_back({ADDR_W'(addr), word});
    endtask

    // Unused fields get junk so the encoder's "ignore" behaviour is exercised.
    task automatic set_cmd(input logic [2:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [5:0] funct,
                           input logic [15:0] imm, input logic [25:0] target);
        cmd_kind   = kind;
        cmd_rs     = rs;
        cmd_rt     = rt;
        cmd_rd     = rd;
        cmd_funct  = funct;
        cmd_imm    = imm;
        cmd_target = target;
        cmd_valid  = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Write monitor: every im_we must match the oldest queued expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 || im_we === 1'b1) begin
            if (im_we !== 1'b0) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_write", 64'(im_we), 64'd0);
                end else begin
                    logic [ADDR_W+31:0] e;
                    e = sb_q.pop_front();
                    chk("write_addr_data", 64'({im_addr, im_wdata}), 64'(e));
                end
            end
        end
    end

    localparam logic [31:0] W_ADDI = 32'h20080005;
    localparam logic [31:0] W_R    = 32'h01095020;
    localparam logic [31:0] W_LW   = 32'h8FA80004;
    localparam logic [31:0] W_J    = 32'h08000010;
    localparam logic [31:0] W_BNE  = 32'h1500FFFF;
    localparam logic [31:0] W_ORI  = 32'h340900FF;

    initial begin
        reset = 1'b0; prog_start = 1'b0; prog_end = 1'b0; cmd_valid = 1'b0;
        cmd_kind = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
        cmd_funct = '0; cmd_imm = '0; cmd_target = '0;
        repeat (3) cyc();

        // Reset values
        chk("rst_we",    64'(im_we),     64'd0);
        chk("rst_addr",  64'(im_addr),   64'd0);
        chk("rst_wdata", 64'(im_wdata),  64'd0);
        chk("rst_count", 64'(count),     64'd0);
        chk("rst_full",  64'(full),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_ready", 64'(cmd_ready), 64'd0);

        reset = 1'b1;
        cyc();
        chk("idle_ready", 64'(cmd_ready), 64'd0);

        // Enter LOAD
        prog_start = 1'b1; cyc(); prog_start = 1'b0;
        chk("load_ready", 64'(cmd_ready), 64'd1);
        chk("load_count", 64'(count),     64'd0);

        // ADDI -> addr 0
        set_cmd(3'd4, 5'd0, 5'd8, 5'd31, 6'h3F, 16'h0005, 26'h3FFFFFF); push(0, W_ADDI);
        cyc(); cmd_valid = 1'b0;
        chk("addi_count", 64'(count), 64'd1);

        // R then LW back to back -> addr 1, 2
        set_cmd(3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'hBEEF, 26'h1234567); push(1, W_R);
        cyc();
        set_cmd(3'd1, 5'd29, 5'd8, 5'd7, 6'h15, 16'h0004, 26'h2AAAAAA); push(2, W_LW);
        cyc(); cmd_valid = 1'b0;
        chk("b2b_count", 64'(count), 64'd3);

        // J fills the last word -> DONE by capacity
        set_cmd(3'd5, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000010); push(3, W_J);
        cyc(); cmd_valid = 1'b0;
        chk("fill_count", 64'(count),     64'd4);
        chk("fill_full",  64'(full),      64'd1);
        chk("fill_done",  64'(done),      64'd1);
        chk("fill_ready", 64'(cmd_ready), 64'd0);

        // Command offered while full is not accepted (no push)
        set_cmd(3'd7, 5'd8, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);
        cyc(); cyc(); cmd_valid = 1'b0;
        chk("full_hold_count", 64'(count), 64'd4);

        // Restart from DONE: J, BNE, ORI
        prog_start = 1'b1; cyc(); prog_start = 1'b0;
        chk("restart_done", 64'(done), 64'd0);
        set_cmd(3'd5, 5'd3, 5'd4, 5'd5, 6'h11, 16'h7777, 26'h0000010); push(0, W_J);
        cyc();
        set_cmd(3'd7, 5'd8, 5'd0, 5'd9, 6'h2A, 16'hFFFF, 26'h3FFFFFF); push(1, W_BNE);
        cyc();
        set_cmd(3'd6, 5'd0, 5'd9, 5'd1, 6'h01, 16'h00FF, 26'h0000001); push(2, W_ORI);
        cyc(); cmd_valid = 1'b0;
        chk("jbo_count", 64'(count), 64'd3);

        // prog_start with simultaneous accept after 3 words -> addr 0, count 1
        prog_start = 1'b1;
        set_cmd(3'd4, 5'd0, 5'd8, 5'd0, 6'h0, 16'h0005, 26'h0); push(0, W_ADDI);
        cyc(); prog_start = 1'b0; cmd_valid = 1'b0;
        chk("ps_acc_count", 64'(count),     64'd1);
        chk("ps_acc_done",  64'(done),      64'd0);
        chk("ps_acc_ready", 64'(cmd_ready), 64'd1);

        // prog_end with simultaneous accept: word written, then DONE
        prog_end = 1'b1;
        set_cmd(3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'h0, 26'h0); push(1, W_R);
        cyc(); prog_end = 1'b0; cmd_valid = 1'b0;
        chk("pe_acc_count", 64'(count),     64'd2);
        chk("pe_acc_done",  64'(done),      64'd1);
        chk("pe_acc_full",  64'(full),      64'd0);
        chk("pe_acc_ready", 64'(cmd_ready), 64'd0);

        // prog_end in DONE is ignored; prog_start+prog_end together -> LOAD
        prog_end = 1'b1; cyc(); prog_end = 1'b0;
        chk("pe_done_done",  64'(done),  64'd1);
        chk("pe_done_count", 64'(count), 64'd2);
        prog_start = 1'b1; prog_end = 1'b1; cyc(); prog_start = 1'b0; prog_end = 1'b0;
        chk("both_done",  64'(done),      64'd0);
        chk("both_ready", 64'(cmd_ready), 64'd1);
        chk("both_count", 64'(count),     64'd0);

        // cmd_valid held for 5 cycles: exactly 4 accepts, addrs 0..3
        for (int i = 0; i < 4; i++) push(i, W_LW);
        set_cmd(3'd1, 5'd29, 5'd8, 5'd0, 6'h0, 16'h0004, 26'h0);
        repeat (5) cyc();
        cmd_valid = 1'b0;
        chk("held_count", 64'(count),     64'd4);
        chk("held_full",  64'(full),      64'd1);
        chk("held_done",  64'(done),      64'd1);
        chk("held_ready", 64'(cmd_ready), 64'd0);

        // Reset the cycle after an accept: the registered write already on the
        // port is visible for that cycle, then reset clears everything.
        prog_start = 1'b1; cyc(); prog_start = 1'b0;
        set_cmd(3'd4, 5'd0, 5'd8, 5'd0, 6'h0, 16'h0005, 26'h0); push(0, W_ADDI);
        cyc(); cmd_valid = 1'b0; reset = 1'b0;
        cyc();
        chk("mid_rst_we",    64'(im_we),     64'd0);
        chk("mid_rst_addr",  64'(im_addr),   64'd0);
        chk("mid_rst_wdata", 64'(im_wdata),  64'd0);
        chk("mid_rst_count", 64'(count),     64'd0);
        chk("mid_rst_done",  64'(done),      64'd0);
        chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
        reset = 1'b1;
        cyc();
        chk("post_rst_ready0", 64'(cmd_ready), 64'd0);
        cyc();
        chk("post_rst_ready1", 64'(cmd_ready), 64'd0);
        prog_start = 1'b1; cyc(); prog_start = 1'b0;
        chk("post_rst_start_ready", 64'(cmd_ready), 64'd1);
        cyc();

        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
